// File: rtl/shuttle_ctrl.sv
// Single-axis shuttle motor controller: synchronised switches, debounced start/abort key,
// move timeout with latched fault, and optional auto-return after a dwell at either limit.
module shuttle_ctrl #(
    parameter int DB_CYC   = 4,
    parameter int TO_CYC   = 64,
    parameter int HOLD_CYC = 8,
    parameter bit AUTO_RET = 1'b0,
    parameter bit SW_ACT   = 1'b0
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       key,
    input  logic       catcher,
    input  logic       jockey_l,
    input  logic       jockey_r,
    input  logic       fault_clr,
    output logic       enable,
    output logic       direct,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVE_R = 3'd1,
        MOVE_L = 3'd2,
        DWELL  = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam int DBW = $clog2(DB_CYC + 1);
    localparam int TW  = $clog2(TO_CYC + 1);
    localparam int HW  = $clog2(HOLD_CYC + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYC - 1);
    localparam logic [HW-1:0]  HD_LAST = HW'(HOLD_CYC - 1);

    // Synchroniser bit order: {jockey_r, jockey_l, catcher, key}
    logic [3:0]     meta_q, meta_d, sync_q, sync_d;
    logic           key_db_q, key_db_d, key_prev_q, key_prev_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [HW-1:0]  dwell_q, dwell_d;
    logic           enable_q, enable_d, direct_q, direct_d;
    logic           busy_q, busy_d, fault_q, fault_d;
    logic [2:0]     state_o_q, state_o_d;
    logic           key_evt, lim_l, lim_r, lim_c, both_lim;

    assign key_evt  = key_db_q & ~key_prev_q;
    assign lim_c    = (sync_q[1] == SW_ACT);
    assign lim_l    = (sync_q[2] == SW_ACT);
    assign lim_r    = (sync_q[3] == SW_ACT);
    assign both_lim = lim_l & lim_r;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        meta_d     = {jockey_r, jockey_l, catcher, key};
        sync_d     = meta_q;
        key_db_d   = key_db_q;
        key_prev_d = key_db_q;
        db_cnt_d   = '0;
        state_d    = state_q;
        timer_d    = '0;
        dwell_d    = '0;

        if (sync_q[0] != key_db_q) begin
            if (db_cnt_q == DB_LAST) key_db_d = sync_q[0];
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (key_evt) begin
                    if (both_lim)   state_d = FAULT;
                    else if (lim_l) state_d = MOVE_R;
                    else            state_d = MOVE_L;
                end
            end
            MOVE_R, MOVE_L: begin
                if (both_lim)                                     state_d = FAULT;
                else if ((state_q == MOVE_R) ? lim_r : lim_l)     state_d = DWELL;
                else if (timer_q == TO_LAST)                      state_d = FAULT;
                else if (key_evt)                                 state_d = IDLE;
                else timer_d = (timer_q == TO_LAST) ? timer_q : timer_q + 1'b1;
            end
            DWELL: begin
                if (key_evt) state_d = IDLE;
                else if (AUTO_RET && lim_c) begin
                    // direct still remembers which end we arrived at
                    if (dwell_q == HD_LAST) state_d = direct_q ? MOVE_L : MOVE_R;
                    else dwell_d = (dwell_q == HD_LAST) ? dwell_q : dwell_q + 1'b1;
                end else state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr && !both_lim) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        enable_d  = (state_d == MOVE_R) || (state_d == MOVE_L);
        busy_d    = enable_d || (state_d == DWELL);
        fault_d   = (state_d == FAULT);
        state_o_d = state_d;
        direct_d  = (state_d == MOVE_R) ? 1'b1 : (state_d == MOVE_L) ? 1'b0 : direct_q;
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (s_rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            key_db_q   <= 1'b0;
            key_prev_q <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            timer_q    <= '0;
            dwell_q    <= '0;
            enable_q   <= 1'b0;
            direct_q   <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            state_o_q  <= '0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            key_db_q   <= key_db_d;
            key_prev_q <= key_prev_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            dwell_q    <= dwell_d;
            enable_q   <= enable_d;
            direct_q   <= direct_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            state_o_q  <= state_o_d;
        end
    end

    assign enable  = enable_q;
    assign direct  = direct_q;
    assign busy    = busy_q;
    assign fault   = fault_q;
    assign state_o = state_o_q;
endmodule

// File: tb/tb_shuttle_ctrl.sv
// Bench for shuttle_ctrl: two instances (AUTO_RET=0 / AUTO_RET=1) share stimulus and are
// compared every cycle against a cycle-level behavioural model, plus directed literal checks.
module tb_shuttle_ctrl;
    localparam int DB_CYC   = 4;
    localparam int TO_CYC   = 64;
    localparam int HOLD_CYC = 8;
    localparam bit SW_ACT   = 1'b0;

    logic sclk = 1'b0, s_rst = 1'b1;
    logic key = 1'b0, catcher = 1'b1, jockey_l = 1'b1, jockey_r = 1'b1, fault_clr = 1'b0;
    logic [1:0] en, dir, bsy, flt;
    logic [2:0] st0, st1;

    shuttle_ctrl #(.DB_CYC(DB_CYC), .TO_CYC(TO_CYC), .HOLD_CYC(HOLD_CYC),
                   .AUTO_RET(1'b0), .SW_ACT(SW_ACT)) dut0 (
        .sclk(sclk), .s_rst(s_rst), .key(key), .catcher(catcher), .jockey_l(jockey_l),
        .jockey_r(jockey_r), .fault_clr(fault_clr), .enable(en[0]), .direct(dir[0]),
        .busy(bsy[0]), .fault(flt[0]), .state_o(st0));

    shuttle_ctrl #(.DB_CYC(DB_CYC), .TO_CYC(TO_CYC), .HOLD_CYC(HOLD_CYC),
                   .AUTO_RET(1'b1), .SW_ACT(SW_ACT)) dut1 (
        .sclk(sclk), .s_rst(s_rst), .key(key), .catcher(catcher), .jockey_l(jockey_l),
        .jockey_r(jockey_r), .fault_clr(fault_clr), .enable(en[1]), .direct(dir[1]),
        .busy(bsy[1]), .fault(flt[1]), .state_o(st1));

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state numbers 0 idle, 1 moving right, 2 moving left, 3 dwell, 4 fault
    int  m_st[2], m_tmr[2], m_dw[2];
    bit  m_dir[2];
    bit [3:0] m_meta, m_sync;
    bit  m_db, m_db_prev;
    int  m_run;

    function automatic bit act_lvl(input bit v);
        return v == SW_ACT;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_tmr[i] = 0; m_dw[i] = 0; m_dir[i] = 1'b0;
        end
        m_meta = '0; m_sync = '0; m_db = 1'b0; m_db_prev = 1'b0; m_run = 0;
    endtask

    task automatic model_step();
        bit evt, l, r, c;
        evt = m_db && !m_db_prev;
        c = act_lvl(m_sync[1]); l = act_lvl(m_sync[2]); r = act_lvl(m_sync[3]);
        for (int i = 0; i < 2; i++) begin
            int nxt;
            nxt = m_st[i];
            case (m_st[i])
                0: if (evt) nxt = (l && r) ? 4 : (l ? 1 : 2);
                1, 2: begin
                    if (l && r)                            nxt = 4;
                    else if ((m_st[i] == 1) ? r : l)       nxt = 3;
                    else if (m_tmr[i] >= TO_CYC - 1)       nxt = 4;
                    else if (evt)                          nxt = 0;
                end
                3: begin
                    if (evt) nxt = 0;
                    else if (i == 1 && c) begin
                        if (m_dw[i] + 1 >= HOLD_CYC) nxt = m_dir[i] ? 2 : 1;
                    end else nxt = 0;
                end
                4: if (fault_clr && !(l && r)) nxt = 0;
                default: nxt = 0;
            endcase
            m_tmr[i] = (nxt == m_st[i] && (nxt == 1 || nxt == 2)) ? m_tmr[i] + 1 : 0;
            m_dw[i]  = (nxt == 3 && m_st[i] == 3) ? m_dw[i] + 1 : 0;
            if (nxt == 1) m_dir[i] = 1'b1;
            if (nxt == 2) m_dir[i] = 1'b0;
            m_st[i] = nxt;
        end
        // accept a new key level once it has differed for DB_CYC consecutive samples
        m_db_prev = m_db;
        if (m_sync[0] != m_db) m_run++;
        else                   m_run = 0;
        if (m_run == DB_CYC) begin
            m_db = m_sync[0];
            m_run = 0;
        end
        m_sync = m_meta;
        m_meta = {jockey_r, jockey_l, catcher, key};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sclk or posedge s_rst);
            if (s_rst) model_reset();
            else       model_step();
        end
    end

    initial begin
        forever begin
            @(negedge sclk);
            if (!s_rst) begin
                for (int i = 0; i < 2; i++) begin
                    int s;
                    s = (i == 0) ? int'(st0) : int'(st1);
                    check($sformatf("cmp%0d_state", i), s, m_st[i]);
                    check($sformatf("cmp%0d_enable", i), int'(en[i]), int'(m_st[i] == 1 || m_st[i] == 2));
                    check($sformatf("cmp%0d_busy", i), int'(bsy[i]), int'(m_st[i] >= 1 && m_st[i] <= 3));
                    check($sformatf("cmp%0d_fault", i), int'(flt[i]), int'(m_st[i] == 4));
                    check($sformatf("cmp%0d_direct", i), int'(dir[i]), int'(m_dir[i]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic press(input int n);
        key = 1'b1;
        cyc(n);
        key = 1'b0;
    endtask

    function automatic int get_st(input int inst);
        return (inst == 0) ? int'(st0) : int'(st1);
    endfunction

    task automatic wait_st(input int inst, input int want, input int bound, input string name);
        int hit;
        hit = 0;
        for (int i = 0; i < bound && hit == 0; i++) begin
            cyc(1);
            if (get_st(inst) == want) hit = 1;
        end
        check(name, hit, 1);
    endtask

    initial begin
        int hit, n;
        // 1: reset holds everything at zero while inputs toggle
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            key = 1'($urandom_range(0, 1)); catcher = 1'($urandom_range(0, 1));
            jockey_l = 1'($urandom_range(0, 1)); jockey_r = 1'($urandom_range(0, 1));
            fault_clr = 1'($urandom_range(0, 1));
            check("rst_outputs_zero", int'({en, dir, bsy, flt, st0, st1}), 0);
        end
        key = 1'b0; catcher = 1'b1; jockey_l = 1'b1; jockey_r = 1'b1; fault_clr = 1'b0;
        cyc(1);
        s_rst = 1'b0;
        cyc(4);

        // 2: short key pulse ignored, long press starts MOVE_R from the left end
        jockey_l = 1'b0;
        cyc(3);
        press(2);
        cyc(10);
        check("short_pulse_ignored", int'(st0), 0);
        hit = 0;
        key = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (hit == 0 && st0 == 3'd1) hit = i;
        end
        key = 1'b0;
        check("start_latency_ok", int'(hit > 0 && hit <= 2 + DB_CYC + 2), 1);
        check("move_r_state", int'(st0), 1);
        check("move_r_direct", int'(dir[0]), 1);
        check("move_r_enable", int'(en[0]), 1);

        // 3: right limit reached -> one DWELL cycle then IDLE
        jockey_l = 1'b1;
        cyc(12);
        jockey_r = 1'b0;
        wait_st(0, 3, 10, "reach_dwell");
        cyc(1);
        check("dwell_then_idle", int'(st0), 0);
        check("idle_enable", int'(en[0]), 0);
        check("idle_direct_held", int'(dir[0]), 1);

        // 4: MOVE_L with no limit times out after TO_CYC cycles
        cyc(4);
        n = 0;
        key = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (st0 == 3'd2) n++;
        end
        key = 1'b0;
        jockey_r = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (st0 != 3'd2) break;
            n++;
        end
        check("timeout_len", n, TO_CYC);
        check("timeout_state", int'(st0), 4);
        check("timeout_fault", int'(flt[0]), 1);
        check("timeout_enable", int'(en[0]), 0);
        press(8);
        cyc(10);
        check("fault_key_ignored", int'(st0), 4);
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        check("fault_clr_state", int'(st0), 0);
        check("fault_clr_fault", int'(flt[0]), 0);

        // 6: both limits mid-move -> FAULT; clear blocked while both active; key abort
        jockey_l = 1'b0;
        cyc(3);
        press(8);
        check("t6_move_r", int'(st0), 1);
        jockey_l = 1'b1;
        cyc(4);
        jockey_l = 1'b0; jockey_r = 1'b0;
        wait_st(0, 4, 6, "both_limits_fault");
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        cyc(1);
        check("clr_blocked_both", int'(st0), 4);
        jockey_l = 1'b1; jockey_r = 1'b1;
        cyc(4);
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        check("clr_after_release", int'(st0), 0);
        press(8);
        cyc(10);
        check("home_move_l", int'(st0), 2);
        press(8);
        check("abort_idle", int'(st0), 0);
        cyc(10);

        // 5: auto-return instance dwells HOLD_CYC cycles, then heads back left
        jockey_l = 1'b0;
        cyc(3);
        press(8);
        check("ar_move_r", int'(st1), 1);
        jockey_l = 1'b1; catcher = 1'b0;
        cyc(10);
        jockey_r = 1'b0;
        hit = 0;
        for (int i = 0; i < 10 && hit == 0; i++) begin
            cyc(1);
            if (en[1] == 1'b0) hit = 1;
        end
        check("ar_stop_seen", hit, 1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (en[1] != 1'b0) break;
            n++;
        end
        check("ar_dwell_len", n, HOLD_CYC);
        check("ar_return_state", int'(st1), 2);
        check("ar_return_dir", int'(dir[1]), 0);
        check("ar_return_en", int'(en[1]), 1);
        check("noar_idle", int'(st0), 0);
        catcher = 1'b1; jockey_r = 1'b1;
        cyc(5);
        jockey_l = 1'b0;
        wait_st(1, 0, 10, "ar_home_idle");
        cyc(4);

        // 1b: asynchronous reset mid-move
        press(8);
        check("rst_move_r", int'(st0), 1);
        jockey_l = 1'b1;
        cyc(5);
        #2 s_rst = 1'b1;
        #1 check("rst_async_enable", int'(en), 0);
        cyc(1);
        s_rst = 1'b0;
        cyc(1);
        check("rst_release_state", int'({st0, st1}), 0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
